// File: rtl/bitnet_pkg.sv
// Shared types for the bitnet training front end: sequencer state encoding
// and the default statistics counter width.
package bitnet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        CMP  = 2'd2,
        BWD  = 2'd3
    } seq_state_t;

    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/train_sequencer_if.sv
// Sample-source handshake bundle: the source (master) offers x/y with valid,
// the sequencer (slave) answers with ready.
interface train_sequencer_if #(
    parameter int IN_W  = 3,
    parameter int OUT_W = 2
);
    logic             sample_valid;
    logic [IN_W-1:0]  sample_x;
    logic [OUT_W-1:0] sample_y;
    logic             sample_ready;

    modport master (output sample_valid, output sample_x, output sample_y, input sample_ready);
    modport slave  (input sample_valid, input sample_x, input sample_y, output sample_ready);
endinterface

// File: rtl/train_sequencer_prop_wave.sv
// Registered one-hot propagation wave across DEPTH layers; dir=0 walks bit 0 upward,
// dir=1 walks the top bit downward. last flags the final layer of the current wave.
module prop_wave #(
    parameter int DEPTH = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start,
    input  logic             dir,
    output logic [DEPTH-1:0] wave,
    output logic             last
);
    localparam logic [DEPTH-1:0] LOW_BIT  = DEPTH'(1'b1);
    localparam logic [DEPTH-1:0] HIGH_BIT = LOW_BIT << (DEPTH - 1);

    logic [DEPTH-1:0] wave_q;
    logic [DEPTH-1:0] wave_d;

    // Shifting past the end layer empties the wave, so it self-terminates.
    always_comb begin
        wave_d = wave_q;
        if (start) begin
            wave_d = dir ? HIGH_BIT : LOW_BIT;
        end else if (dir) begin
            wave_d = wave_q >> 1'b1;
        end else begin
            wave_d = wave_q << 1'b1;
        end
    end

    // Wave register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wave_q <= '0;
        end else begin
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;
    assign last = dir ? wave_q[0] : wave_q[DEPTH-1];
endmodule

// File: rtl/train_sequencer.sv
// Training front end: accepts one (x, y) sample, runs the forward wave, compares
// the last layer's outputs with y, optionally runs the backward wave, keeps statistics.
module train_sequencer
    import bitnet_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IN_W  = 3,
    parameter int OUT_W = 2,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk_in,
    input  logic                rst_in,
    train_sequencer_if.slave    smp,
    input  logic                train_en,
    input  logic                clear_stats,
    output logic [IN_W-1:0]     net_fin,
    input  logic [OUT_W-1:0]    net_fout,
    output logic [OUT_W-1:0]    net_bin,
    output logic [DEPTH-1:0]    fd_prop,
    output logic [DEPTH-1:0]    bk_prop,
    output logic                oscillator,
    output logic                busy,
    output logic [CNT_W-1:0]    sample_count,
    output logic [CNT_W-1:0]    err_count
);
    seq_state_t       state_q, state_d;
    logic [IN_W-1:0]  x_q, x_d;
    logic [OUT_W-1:0] y_q, y_d;
    logic [OUT_W-1:0] bin_q, bin_d;
    logic             train_q, train_d;
    logic             osc_q, osc_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] sc_q, sc_d;
    logic [CNT_W-1:0] ec_q, ec_d;

    logic [OUT_W-1:0] err_s;
    logic             fd_start_s, bk_start_s;
    logic             fd_last_s, bk_last_s;
    logic             cmp_s;

    prop_wave #(.DEPTH(DEPTH)) u_fwd_wave (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .start  (fd_start_s),
        .dir    (1'b0),
        .wave   (fd_prop),
        .last   (fd_last_s)
    );

    prop_wave #(.DEPTH(DEPTH)) u_bwd_wave (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .start  (bk_start_s),
        .dir    (1'b1),
        .wave   (bk_prop),
        .last   (bk_last_s)
    );

    // Next-state logic for the sample FSM, captured operands, statistics and oscillator.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        bin_d      = bin_q;
        train_d    = train_q;
        osc_d      = osc_q;
        fd_start_s = 1'b0;
        bk_start_s = 1'b0;
        cmp_s      = 1'b0;
        err_s      = net_fout ^ y_q;

        case (state_q)
            IDLE: begin
                if (ready_q && smp.sample_valid) begin
                    state_d    = FWD;
                    x_d        = smp.sample_x;
                    y_d        = smp.sample_y;
                    train_d    = train_en;
                    fd_start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            FWD: begin
                if (fd_last_s) begin
                    state_d = CMP;
                end else begin
                    state_d = FWD;
                end
            end
            CMP: begin
                cmp_s = 1'b1;
                bin_d = err_s;
                if (train_q) begin
                    state_d    = BWD;
                    bk_start_s = 1'b1;
                end else begin
                    state_d = IDLE;
                    osc_d   = ~osc_q;
                end
            end
            BWD: begin
                if (bk_last_s) begin
                    state_d = IDLE;
                    osc_d   = ~osc_q;
                end else begin
                    state_d = BWD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear in the compare cycle overrides that cycle's increment.
        if (clear_stats) begin
            sc_d = '0;
            ec_d = '0;
        end else if (cmp_s) begin
            sc_d = sc_q + CNT_W'(1'b1);
            ec_d = ((|err_s) && (ec_q != '1)) ? ec_q + CNT_W'(1'b1) : ec_q;
        end else begin
            sc_d = sc_q;
            ec_d = ec_q;
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and registered outputs; ready stays low until the first edge after reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            bin_q   <= '0;
            train_q <= 1'b0;
            osc_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            sc_q    <= '0;
            ec_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            bin_q   <= bin_d;
            train_q <= train_d;
            osc_q   <= osc_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            sc_q    <= sc_d;
            ec_q    <= ec_d;
        end
    end

    assign smp.sample_ready = ready_q;
    assign net_fin          = x_q;
    assign net_bin          = bin_q;
    assign oscillator       = osc_q;
    assign busy             = busy_q;
    assign sample_count     = sc_q;
    assign err_count        = ec_q;
endmodule

// File: tb/tb_train_sequencer.sv
// Randomized scoreboard bench for train_sequencer: the driver pushes the expected
// outcome of each accepted sample, a monitor checks each pass cycle by cycle.
module tb_train_sequencer;
    localparam int DEPTH   = 4;
    localparam int IN_W    = 3;
    localparam int OUT_W   = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [IN_W-1:0]  x;
        logic [OUT_W-1:0] bin;
        logic             train;
        int               sc;
        int               ec;
        logic             osc;
        bit               b2b;
    } exp_t;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             train_en;
    logic             clear_stats;
    logic [IN_W-1:0]  net_fin;
    logic [OUT_W-1:0] net_fout;
    logic [OUT_W-1:0] net_bin;
    logic [DEPTH-1:0] fd_prop;
    logic [DEPTH-1:0] bk_prop;
    logic             oscillator;
    logic             busy;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;

    train_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) sif ();

    train_sequencer #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .smp          (sif),
        .train_en     (train_en),
        .clear_stats  (clear_stats),
        .net_fin      (net_fin),
        .net_fout     (net_fout),
        .net_bin      (net_bin),
        .fd_prop      (fd_prop),
        .bk_prop      (bk_prop),
        .oscillator   (oscillator),
        .busy         (busy),
        .sample_count (sample_count),
        .err_count    (err_count)
    );

    always #5 clk_in = ~clk_in;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   m_sc = 0;
    int   m_ec = 0;
    logic m_osc = 1'b0;
    bit   prev_hold = 1'b0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected view of pass cycle k (1..n busy, n+1 the idle cycle after completion).
    task automatic check_cycle(input exp_t t, input int k, input int n);
        logic [31:0] fd_e;
        logic [31:0] bk_e;
        fd_e = (k <= DEPTH) ? (32'd1 << (k - 1)) : 32'd0;
        bk_e = (t.train && k >= DEPTH + 2 && k <= n) ? (32'd1 << (2 * DEPTH + 1 - k)) : 32'd0;
        if (k <= n) begin
            chk("busy_in_pass", 32'(busy), 32'd1);
            chk("ready_in_pass", 32'(sif.sample_ready), 32'd0);
            chk("fd_prop", 32'(fd_prop), fd_e);
            chk("bk_prop", 32'(bk_prop), bk_e);
            if (k == 1) chk("net_fin_capture", 32'(net_fin), 32'(t.x));
            if (k == DEPTH + 2) begin
                chk("net_bin_after_cmp", 32'(net_bin), 32'(t.bin));
                chk("sample_count_after_cmp", 32'(sample_count), 32'(t.sc));
                chk("err_count_after_cmp", 32'(err_count), 32'(t.ec));
            end
        end else begin
            chk("busy_done", 32'(busy), 32'd0);
            chk("ready_done", 32'(sif.sample_ready), 32'd1);
            chk("fd_prop_idle", 32'(fd_prop), 32'd0);
            chk("bk_prop_idle", 32'(bk_prop), 32'd0);
            chk("net_bin_done", 32'(net_bin), 32'(t.bin));
            chk("sample_count_done", 32'(sample_count), 32'(t.sc));
            chk("err_count_done", 32'(err_count), 32'(t.ec));
            chk("oscillator_done", 32'(oscillator), 32'(t.osc));
            chk("net_fin_hold", 32'(net_fin), 32'(t.x));
        end
    endtask

    // Monitor: each rising busy starts a pass, checked against the oldest expectation.
    initial begin : monitor
        bit   prev_busy;
        int   idle_cnt;
        int   n;
        exp_t t;
        prev_busy = 1'b0;
        idle_cnt  = 0;
        wait (mon_en);
        forever begin
            @(negedge clk_in);
            if (busy === 1'b1 && !prev_busy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept actual=accept required=none at %0t", $time);
                end else begin
                    t = exp_q.pop_front();
                    if (t.b2b) chk("b2b_idle_gap", 32'(idle_cnt), 32'd1);
                    n = t.train ? 2 * DEPTH + 1 : DEPTH + 1;
                    for (int k = 1; k <= n + 1; k++) begin
                        if (k > 1) @(negedge clk_in);
                        check_cycle(t, k, n);
                    end
                    idle_cnt = 0;
                end
            end
            if (busy === 1'b1) begin
                idle_cnt = 0;
            end else begin
                idle_cnt++;
            end
            prev_busy = (busy === 1'b1);
        end
    end

    task automatic send(input logic [IN_W-1:0] x, input logic [OUT_W-1:0] y, input logic tr,
                        input logic [OUT_W-1:0] fo, input bit hold, input bit clr_cmp);
        int               waitc;
        exp_t             e;
        logic [OUT_W-1:0] err;
        waitc = 0;
        @(negedge clk_in);
        sif.sample_valid = 1'b1;
        sif.sample_x     = x;
        sif.sample_y     = y;
        train_en         = tr;
        while (sif.sample_ready !== 1'b1 && waitc < 100) begin
            @(negedge clk_in);
            waitc++;
        end
        checks++;
        if (sif.sample_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout actual=%0d_cycles required=ready at %0t", waitc, $time);
            sif.sample_valid = 1'b0;
            prev_hold = 1'b0;
        end else begin
            net_fout = fo;
            err = fo ^ y;
            if (clr_cmp) begin
                m_sc = 0;
                m_ec = 0;
            end else begin
                m_sc = (m_sc + 1) % (1 << CNT_W);
                if (err != '0 && m_ec < CNT_MAX) m_ec++;
            end
            m_osc = ~m_osc;
            e.x = x; e.bin = err; e.train = tr; e.sc = m_sc; e.ec = m_ec; e.osc = m_osc;
            e.b2b = prev_hold;
            exp_q.push_back(e);
            prev_hold = hold;
            @(posedge clk_in);
            #1;
            sif.sample_x = IN_W'($urandom);
            sif.sample_y = OUT_W'($urandom);
            train_en     = 1'($urandom);
            if (!hold) sif.sample_valid = 1'b0;
            if (clr_cmp) begin
                repeat (DEPTH) @(posedge clk_in);
                @(negedge clk_in);
                clear_stats = 1'b1;
                @(posedge clk_in);
                #1 clear_stats = 1'b0;
            end
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && sif.sample_ready !== 1'b1; i++) @(negedge clk_in);
    endtask

    task automatic clear_idle();
        @(negedge clk_in);
        wait_idle();
        clear_stats = 1'b1;
        @(posedge clk_in);
        #1 clear_stats = 1'b0;
        m_sc = 0;
        m_ec = 0;
    endtask

    initial begin : driver
        rst_in           = 1'b1;
        sif.sample_valid = 1'b0;
        sif.sample_x     = '0;
        sif.sample_y     = '0;
        train_en         = 1'b0;
        clear_stats      = 1'b0;
        net_fout         = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_ready", 32'(sif.sample_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fd", 32'(fd_prop), 32'd0);
        chk("rst_bk", 32'(bk_prop), 32'd0);
        chk("rst_fin", 32'(net_fin), 32'd0);
        chk("rst_bin", 32'(net_bin), 32'd0);
        chk("rst_osc", 32'(oscillator), 32'd0);
        chk("rst_counts", 32'({sample_count, err_count}), 32'd0);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("ready_after_release", 32'(sif.sample_ready), 32'd1);

        // Reset aborting a forward wave in its second layer.
        sif.sample_valid = 1'b1;
        sif.sample_x     = 3'b111;
        sif.sample_y     = 2'b11;
        train_en         = 1'b1;
        @(posedge clk_in);
        #1 sif.sample_valid = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("pre_abort_fd", 32'(fd_prop), 32'd2);
        #1 rst_in = 1'b1;
        #1;
        chk("abort_fd", 32'(fd_prop), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(sif.sample_ready), 32'd0);
        chk("abort_counts", 32'({sample_count, err_count}), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        chk("abort_ready_release", 32'(sif.sample_ready), 32'd1);
        chk("abort_osc", 32'(oscillator), 32'd0);
        mon_en = 1'b1;

        send(3'b101, 2'b10, 1'b1, 2'b10, 1'b0, 1'b0);
        send(3'b101, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0);
        send(3'b011, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0);
        clear_idle();
        send(3'b001, 2'b00, 1'b1, 2'b11, 1'b1, 1'b0);
        send(3'b110, 2'b11, 1'b0, 2'b11, 1'b1, 1'b0);
        send(3'b010, 2'b01, 1'b1, 2'b10, 1'b0, 1'b0);
        send(3'b100, 2'b10, 1'b1, 2'b00, 1'b0, 1'b1);
        send(3'b111, 2'b00, 1'b0, 2'b01, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            send(IN_W'($urandom), OUT_W'($urandom), 1'($urandom), OUT_W'($urandom),
                 bit'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0));
        end
        sif.sample_valid = 1'b0;
        prev_hold = 1'b0;

        // Enough erroring samples to saturate err_count and wrap sample_count.
        for (int i = 0; i < 18; i++) begin
            send(IN_W'($urandom), 2'b00, 1'b0, 2'b01, 1'b0, 1'b0);
        end

        for (int i = 0; i < 200 && (exp_q.size() != 0 || busy === 1'b1); i++) @(negedge clk_in);
        repeat (2) @(negedge clk_in);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        chk("err_count_saturated", 32'(err_count), 32'(CNT_MAX));
        chk("sample_count_final", 32'(sample_count), 32'(m_sc));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
